// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: exposure timer plus per-row settle / convert / release
// sequencer between the camera FSM and the pixel array / ADC.
// Optional build macro: PIXEL_CDS_EN adds correlated double sampling
// (PixRst output plus a reset-level second conversion per row).
module pixel_readout_ctrl #(
    parameter int NUM_ROWS      = 2,
    parameter int EXP_W         = 5,
    parameter int SETTLE_CYCLES = 1,
    parameter int ADC_CYCLES    = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Init,
    input  logic [EXP_W-1:0]    ExpTime,
    output logic                Erase,
    output logic                Expose,
    output logic [NUM_ROWS-1:0] NRE,
    output logic                ADC,
    output logic                Busy,
    output logic                Done
`ifdef PIXEL_CDS_EN
    ,
    output logic                PixRst
`endif
);

    localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int DWELL_MAX = (SETTLE_CYCLES > ADC_CYCLES) ? SETTLE_CYCLES : ADC_CYCLES;
    localparam int CNT_W     = $clog2(DWELL_MAX + 1);

    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ADC_LOAD    = CNT_W'(ADC_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        EXPOSE,
        SETTLE,
        CONVERT,
        RELEASE,
        CDS_RST,
        GAP,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [EXP_W-1:0]   exp_cnt, exp_cnt_n;
    // One dwell counter serves settle, CDS reset and ADC phases; it is
    // reloaded on each phase entry and leaves the phase at 1, so it never wraps.
    logic [CNT_W-1:0]   dwell_cnt, dwell_n;
    logic               init_q;
    logic               start;

    logic               erase_n, expose_n, adc_n, busy_n, done_n;
    logic [NUM_ROWS-1:0] nre_n;
`ifdef PIXEL_CDS_EN
    logic               second, second_n;
    logic               pix_rst_n;
`endif

    // Rising edge of Init; init_q resets high so a held Init cannot start a frame.
    assign start = Init & ~init_q;

    // Next-state, counter updates and Moore output decode of the next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n   = state;
        row_n     = row;
        exp_cnt_n = exp_cnt;
        dwell_n   = dwell_cnt;
`ifdef PIXEL_CDS_EN
        second_n  = second;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    exp_cnt_n = (ExpTime == '0) ? EXP_W'(1) : ExpTime;
                    state_n   = EXPOSE;
                end
            end
            EXPOSE: begin
                exp_cnt_n = exp_cnt - EXP_W'(1);
                if (exp_cnt == EXP_W'(1)) begin
                    state_n = SETTLE;
                    dwell_n = SETTLE_LOAD;
                end
            end
            SETTLE, CDS_RST: begin
                dwell_n = dwell_cnt - CNT_W'(1);
                if (dwell_cnt == CNT_W'(1)) begin
                    state_n = CONVERT;
                    dwell_n = ADC_LOAD;
                end
            end
            CONVERT: begin
                dwell_n = dwell_cnt - CNT_W'(1);
                if (dwell_cnt == CNT_W'(1)) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
`ifdef PIXEL_CDS_EN
                // First release leads into the reset-level sample, second ends the row.
                if (!second) begin
                    state_n  = CDS_RST;
                    dwell_n  = SETTLE_LOAD;
                    second_n = 1'b1;
                end else begin
                    state_n  = GAP;
                    second_n = 1'b0;
                end
`else
                state_n = GAP;
`endif
            end
            GAP: begin
                if (row == LAST_ROW) begin
                    state_n = DONE;
                end else begin
                    row_n   = row + ROW_W'(1);
                    state_n = SETTLE;
                    dwell_n = SETTLE_LOAD;
                end
            end
            DONE: begin
                row_n   = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        erase_n  = (state_n == IDLE) || (state_n == DONE);
        expose_n = (state_n == EXPOSE);
        adc_n    = (state_n == CONVERT);
        busy_n   = (state_n != IDLE);
        done_n   = (state_n == DONE);
        nre_n    = (state_n inside {SETTLE, CONVERT, RELEASE, CDS_RST})
                   ? (NUM_ROWS'(1) << row_n) : '0;
`ifdef PIXEL_CDS_EN
        pix_rst_n = (state_n == CDS_RST);
`endif
    end

    // State, counters and registered outputs; asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            row       <= '0;
            exp_cnt   <= '0;
            dwell_cnt <= '0;
            init_q    <= 1'b1;
            Erase     <= 1'b1;
            Expose    <= 1'b0;
            NRE       <= '0;
            ADC       <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef PIXEL_CDS_EN
            second    <= 1'b0;
            PixRst    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            row       <= row_n;
            exp_cnt   <= exp_cnt_n;
            dwell_cnt <= dwell_n;
            init_q    <= Init;
            Erase     <= erase_n;
            Expose    <= expose_n;
            NRE       <= nre_n;
            ADC       <= adc_n;
            Busy      <= busy_n;
            Done      <= done_n;
`ifdef PIXEL_CDS_EN
            second    <= second_n;
            PixRst    <= pix_rst_n;
`endif
        end
    end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
Parametrised exposure and readout sequencer for the pixel array. It replaces the fixed two-row controller and its external exposure-overflow input with an internal exposure timer. It also adds a programmable row count, settle time and ADC pulse width. The block sits between the top-level camera FSM (Init, ExpTime) and the pixel array and ADC (Erase, Expose, NRE, ADC).

Parameters:
- NUM_ROWS, 2, number of readout rows, one NRE bit per row; legal range >= 1.
- EXP_W, 5, width of the ExpTime input and the internal exposure down-counter.
- SETTLE_CYCLES, 1, cycles NRE is held before ADC asserts; legal range >= 1.
- ADC_CYCLES, 1, width of the ADC pulse in cycles; legal range >= 1.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Init  input  1  start request; a rising edge starts one frame.
- ExpTime  input  EXP_W  exposure length in Clk cycles; latched on start.
- Erase  output  1  pixel capacitor erase; high when idle.
- Expose  output  1  exposure enable.
- NRE  output  NUM_ROWS  one-hot row read enable, active-high.
- ADC  output  1  ADC conversion strobe.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset is asynchronous, active-high; clock is Clk.
- Reset values:
  - state=IDLE, Erase=1, all other outputs 0.
  - row=0, counters 0.
  - init_q=1, so a new low-to-high transition of Init is required after reset.
- Outputs are Moore and registered; each is valid in the first cycle of the state that drives it.
- Start detection:
  - start = Init & ~init_q, sampled on the posedge.
  - start is honoured only in IDLE; Init edges in any other state are ignored and not queued.
- IDLE: Erase=1, Busy=0.
  - On start: latch ExpTime into exp_cnt, forcing 1 if ExpTime==0; go to EXPOSE.
- EXPOSE: Erase=0, Expose=1.
  - exp_cnt decrements each cycle; at exp_cnt==1 go to SETTLE.
  - Expose is high for exactly max(ExpTime,1) cycles.
- SETTLE: NRE[row]=1 for SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT: NRE[row]=1, ADC=1 for ADC_CYCLES cycles, then go to RELEASE.
- RELEASE: NRE[row]=1, ADC=0 for 1 cycle, then go to GAP.
- GAP: NRE all 0 for 1 cycle.
  - If row==NUM_ROWS-1, go to DONE.
  - Otherwise row+1 and go to SETTLE.
- DONE: Erase=1, Done=1, Busy=1 for 1 cycle; row clears to 0; go to IDLE.
- Frame length from the start edge to the DONE cycle is E + NUM_ROWS*(SETTLE_CYCLES+ADC_CYCLES+2) + 1 cycles, where E = max(ExpTime,1).
- Invariants:
  - NRE is one-hot or zero.
  - ADC=1 only while exactly one NRE bit is high.
  - Expose and Erase are never both 1.
- Widths:
  - row counter width is max(1, clog2(NUM_ROWS)).
  - settle and ADC counters are sized clog2(max+1); none of them wrap.
- Reset mid-frame: immediate return to reset values; an in-progress ADC or NRE pulse is truncated.
- ExpTime changes after start have no effect until the next frame.

Optional Feature:
- Macro PIXEL_CDS_EN enables correlated double sampling.
- With the macro defined:
  - Adds output PixRst (1 bit, reset 0).
  - After RELEASE, a CDS_RST state holds NRE[row]=1 and PixRst=1 for SETTLE_CYCLES cycles.
  - CDS_RST is followed by a second CONVERT (ADC_CYCLES) and a second RELEASE (1 cycle), then GAP.
  - Per-row cost becomes 2*SETTLE_CYCLES + 2*ADC_CYCLES + 3 cycles.
- Without the macro: there is no PixRst port and the sequence is as above.

Test Plan:
- Nominal frame: defaults, ExpTime=5, Init rises at edge k.
  - Expose=1 at k+1..k+5.
  - NRE=01 at k+6..k+8, with ADC=1 at k+7.
  - GAP at k+9.
  - NRE=10 at k+10..k+12, with ADC=1 at k+11.
  - GAP at k+13.
  - Done=1 and Erase=1 at k+14; IDLE at k+15.
- Zero exposure: ExpTime=0 -> Expose high for exactly 1 cycle, then the normal readout.
- Parametrised run: NUM_ROWS=4, SETTLE_CYCLES=2, ADC_CYCLES=3, ExpTime=10.
  - NRE walks 0001->0010->0100->1000.
  - Each ADC pulse is 3 cycles and starts 2 cycles after its NRE rises.
  - Done occurs at k+10+4*7+1 = k+39.
- Ignored restart: Init toggles during EXPOSE and during readout -> no restart, same Done timing as the nominal frame; Init held high through DONE -> no new frame until Init falls and rises again.
- Async reset: Reset asserted mid-CONVERT of row 1 -> ADC=0, NRE=0, Erase=1, Busy=0 immediately without a clock edge; the next Init rise runs a full frame from row 0.
- CDS build (PIXEL_CDS_EN, defaults, ExpTime=3): each row shows two ADC pulses separated by a 1-cycle PixRst pulse; Done occurs at k+3+2*7+1 = k+18.
